// File: rtl/sample_mem_pkg.sv
// Shared types and helpers for the sample memory: burst FSM states and parity.
package sample_mem_pkg;

   typedef enum logic [1:0] {
      BS_IDLE = 2'd0,
      BS_RUN  = 2'd1,
      BS_LAST = 2'd2
   } burst_state_e;

   localparam int unsigned PARITY_MAX_W = 64;

   // Even parity of a zero-extended word; zero extension does not change the result.
   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/sample_mem_ram.sv
// Storage array: one write port, one registered write-first read port.
// Optional parity storage and check when SAMPLE_MEM_PARITY_EN is defined.
module sample_mem_ram
   import sample_mem_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 64,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_perr_inj,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_perr
);

`ifdef SAMPLE_MEM_PARITY_EN
   localparam int unsigned WORD_W = DATA_W + 1;
`else
   localparam int unsigned WORD_W = DATA_W;
`endif

   logic [WORD_W-1:0] mem [DEPTH];
   logic [WORD_W-1:0] wr_word;
   logic [WORD_W-1:0] rd_word_c;
   logic              wr_ok;
   logic              rd_ok;
   logic              fwd_c;

`ifdef SAMPLE_MEM_PARITY_EN
   assign wr_word = {even_parity(PARITY_MAX_W'(wr_data)) ^ wr_perr_inj, wr_data};
`else
   logic unused_perr_inj;
   assign wr_word         = wr_data;
   assign unused_perr_inj = wr_perr_inj;
`endif

   assign wr_ok = (32'(wr_addr) < DEPTH);
   assign rd_ok = (32'(rd_addr) < DEPTH);
   assign fwd_c = wr_en && wr_ok && (wr_addr == rd_addr);

   // Write-first: a same-cycle write to the read address is forwarded.
   always_comb begin
      rd_word_c = '0;
      if (fwd_c) begin
         rd_word_c = wr_word;
      end else if (rd_ok) begin
         rd_word_c = mem[rd_addr];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && wr_ok) begin
         mem[wr_addr] <= wr_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data <= '0;
         rd_perr <= 1'b0;
      end else if (rd_en) begin
         rd_data <= rd_word_c[DATA_W-1:0];
`ifdef SAMPLE_MEM_PARITY_EN
         rd_perr <= even_parity(PARITY_MAX_W'(rd_word_c));
`else
         rd_perr <= 1'b0;
`endif
      end else begin
         rd_perr <= 1'b0;
      end
   end

endmodule

// File: rtl/sample_mem.sv
// Sample memory with single-word reads and a sequential burst reader.
// Build option SAMPLE_MEM_PARITY_EN adds per-word even parity and rd_perr.
module sample_mem
   import sample_mem_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 64,
   localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_perr_inj,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic              burst_start,
   input  logic [ADDR_W-1:0] burst_base,
   input  logic [ADDR_W:0]   burst_len,
   input  logic              burst_hold,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_perr,
   output logic              burst_busy,
   output logic              burst_done
);

   burst_state_e      state_q, state_nx;
   logic [ADDR_W-1:0] base_q, base_nx;
   logic [ADDR_W-1:0] idx_q, idx_nx;
   logic [ADDR_W:0]   len_q, len_nx;
   logic [ADDR_W:0]   addr_sum_c;
   logic [ADDR_W-1:0] burst_addr_c;
   logic [ADDR_W-1:0] ram_rd_addr_c;
   logic              burst_rd_c;
   logic              last_word_c;
   logic              single_rd_c;
   logic              ram_rd_en_c;

   // Burst address (base + idx) modulo DEPTH, valid for non-power-of-two depths too.
   always_comb begin
      addr_sum_c = {1'b0, base_q} + {1'b0, idx_q};
      if (32'(addr_sum_c) >= DEPTH) begin
         addr_sum_c = addr_sum_c - (ADDR_W+1)'(DEPTH);
      end
      burst_addr_c = addr_sum_c[ADDR_W-1:0];
   end

   always_comb begin
      state_nx    = state_q;
      base_nx     = base_q;
      len_nx      = len_q;
      idx_nx      = idx_q;
      burst_rd_c  = 1'b0;
      last_word_c = 1'b0;
      case (state_q)
         BS_IDLE: begin
            if (burst_start && (burst_len != '0)) begin
               base_nx  = burst_base;
               len_nx   = burst_len;
               idx_nx   = '0;
               state_nx = BS_RUN;
            end
         end
         BS_RUN: begin
            if (!burst_hold) begin
               burst_rd_c = 1'b1;
               if ((ADDR_W+1)'(idx_q) == (len_q - (ADDR_W+1)'(1))) begin
                  last_word_c = 1'b1;
                  state_nx    = BS_LAST;
               end else begin
                  idx_nx = idx_q + ADDR_W'(1);
               end
            end
         end
         BS_LAST: begin
            idx_nx   = '0;
            state_nx = BS_IDLE;
         end
         default: begin
            state_nx = BS_IDLE;
         end
      endcase
      single_rd_c   = rd_en && (state_q == BS_IDLE);
      ram_rd_en_c   = burst_rd_c || single_rd_c;
      ram_rd_addr_c = burst_rd_c ? burst_addr_c : rd_addr;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= BS_IDLE;
         base_q     <= '0;
         len_q      <= '0;
         idx_q      <= '0;
         rd_valid   <= 1'b0;
         burst_busy <= 1'b0;
         burst_done <= 1'b0;
      end else begin
         state_q    <= state_nx;
         base_q     <= base_nx;
         len_q      <= len_nx;
         idx_q      <= idx_nx;
         rd_valid   <= ram_rd_en_c;
         burst_busy <= (state_nx != BS_IDLE);
         burst_done <= last_word_c;
      end
   end

   sample_mem_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_perr_inj (wr_perr_inj),
      .rd_en       (ram_rd_en_c),
      .rd_addr     (ram_rd_addr_c),
      .rd_data     (rd_data),
      .rd_perr     (rd_perr)
   );

endmodule

// File: tb/tb_sample_mem.sv
// Self-checking bench for sample_mem: directed table, burst sequences, random vs. model.
module tb_sample_mem;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 64;
   localparam int unsigned ADDR_W = 6;

   typedef struct packed {
      logic              rst;
      logic              wr_en;
      logic [ADDR_W-1:0] wr_addr;
      logic [DATA_W-1:0] wr_data;
      logic              inj;
      logic              rd_en;
      logic [ADDR_W-1:0] rd_addr;
      logic              bs;
      logic [ADDR_W-1:0] bbase;
      logic [ADDR_W:0]   blen;
      logic              hold;
   } stim_t;

   typedef struct {
      stim_t             s;
      logic              exp_valid;
      logic [DATA_W-1:0] exp_data;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst, wr_en, wr_perr_inj, rd_en, burst_start, burst_hold;
   logic [ADDR_W-1:0] wr_addr, rd_addr, burst_base;
   logic [DATA_W-1:0] wr_data;
   logic [ADDR_W:0]   burst_len;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid, rd_perr, burst_busy, burst_done;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: memory image plus a queue of burst addresses still to issue.
   logic [DATA_W-1:0] m_mem [DEPTH];
   bit                m_inj [DEPTH];
   int                m_q [$];
   bit                m_last = 0;
   logic [DATA_W-1:0] m_data = '0;
   bit                m_valid, m_done, m_busy, m_perr;

   sample_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_perr_inj(wr_perr_inj), .rd_en(rd_en), .rd_addr(rd_addr),
      .burst_start(burst_start), .burst_base(burst_base), .burst_len(burst_len),
      .burst_hold(burst_hold), .rd_data(rd_data), .rd_valid(rd_valid),
      .rd_perr(rd_perr), .burst_busy(burst_busy), .burst_done(burst_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic stim_t nop();
      stim_t s;
      s = '0;
      return s;
   endfunction

   task automatic do_cycle(input stim_t s);
      int src;
      rst = s.rst; wr_en = s.wr_en; wr_addr = s.wr_addr; wr_data = s.wr_data;
      wr_perr_inj = s.inj; rd_en = s.rd_en; rd_addr = s.rd_addr;
      burst_start = s.bs; burst_base = s.bbase; burst_len = s.blen; burst_hold = s.hold;
      src = -1;
      m_valid = 0; m_done = 0;
      if (s.rst) begin
         m_q.delete(); m_last = 0; m_data = '0; m_perr = 0;
      end else begin
         if (m_q.size() > 0 || m_last) begin
            if (m_last) m_last = 0;
            else if (!s.hold) begin
               src = m_q.pop_front();
               m_valid = 1;
               if (m_q.size() == 0) begin m_done = 1; m_last = 1; end
            end
         end else begin
            if (s.rd_en) begin src = int'(s.rd_addr); m_valid = 1; end
            if (s.bs && s.blen != 0)
               for (int k = 0; k < int'(s.blen); k++) m_q.push_back((int'(s.bbase) + k) % DEPTH);
         end
         if (src >= 0) begin
            if (s.wr_en && int'(s.wr_addr) == src) begin m_data = s.wr_data; m_perr = s.inj; end
            else begin m_data = m_mem[src]; m_perr = m_inj[src]; end
         end
         if (s.wr_en) begin m_mem[s.wr_addr] = s.wr_data; m_inj[s.wr_addr] = s.inj; end
      end
      m_busy = (m_q.size() > 0) || m_last;
      @(posedge clk);
      #1;
      check("rd_valid", 32'(rd_valid), 32'(m_valid));
      check("rd_data", 32'(rd_data), 32'(m_data));
      check("burst_busy", 32'(burst_busy), 32'(m_busy));
      check("burst_done", 32'(burst_done), 32'(m_done));
`ifdef SAMPLE_MEM_PARITY_EN
      if (m_valid) check("rd_perr", 32'(rd_perr), 32'(m_perr));
`else
      if (m_valid) check("rd_perr", 32'(rd_perr), 32'd0);
`endif
   endtask

   function automatic stim_t wr(input int a, input int d);
      stim_t s;
      s = nop(); s.wr_en = 1; s.wr_addr = ADDR_W'(a); s.wr_data = DATA_W'(d);
      return s;
   endfunction

   function automatic stim_t rd(input stim_t b, input int a);
      stim_t s;
      s = b; s.rd_en = 1; s.rd_addr = ADDR_W'(a);
      return s;
   endfunction

   function automatic stim_t burst(input int base, input int len);
      stim_t s;
      s = nop(); s.bs = 1; s.bbase = ADDR_W'(base); s.blen = (ADDR_W+1)'(len);
      return s;
   endfunction

   vec_t tbl [10];
   logic [DATA_W-1:0] cap [8];
   int ncap, done_at, dones;
   stim_t s;

   initial begin
      s = nop(); s.rst = 1;
      do_cycle(s);
      do_cycle(s);
      check("reset_valid", 32'(rd_valid), 32'd0);
      check("reset_data", 32'(rd_data), 32'd0);
      check("reset_busy", 32'(burst_busy), 32'd0);
      check("reset_perr", 32'(rd_perr), 32'd0);

      // Directed single-word vectors: write-then-read, write-first, data hold.
      tbl[0] = '{wr(3, 8'hA5), 1'b0, 8'h00};
      tbl[1] = '{rd(nop(), 3), 1'b1, 8'hA5};
      tbl[2] = '{nop(), 1'b0, 8'hA5};
      tbl[3] = '{rd(wr(7, 8'h3C), 7), 1'b1, 8'h3C};
      tbl[4] = '{nop(), 1'b0, 8'h3C};
      tbl[5] = '{rd(wr(10, 8'h55), 3), 1'b1, 8'hA5};
      tbl[6] = '{rd(wr(7, 8'h99), 7), 1'b1, 8'h99};
      tbl[7] = '{rd(nop(), 10), 1'b1, 8'h55};
      tbl[8] = '{wr(63, 8'hFF), 1'b0, 8'h55};
      tbl[9] = '{rd(nop(), 63), 1'b1, 8'hFF};
      for (int i = 0; i < 10; i++) begin
         do_cycle(tbl[i].s);
         check($sformatf("tbl%0d_valid", i), 32'(rd_valid), 32'(tbl[i].exp_valid));
         check($sformatf("tbl%0d_data", i), 32'(rd_data), 32'(tbl[i].exp_data));
      end

      for (int i = 0; i < int'(DEPTH); i++) do_cycle(wr(i, i));
      do_cycle(nop());

      // Wrapping burst 62, len 4.
      do_cycle(burst(62, 4));
      ncap = 0; done_at = -1;
      for (int c = 0; c < 8; c++) begin
         do_cycle(nop());
         if (rd_valid && ncap < 8) begin
            if (burst_done) done_at = ncap;
            cap[ncap] = rd_data; ncap++;
         end
      end
      check("wrap_count", 32'(ncap), 32'd4);
      check("wrap_w0", 32'(cap[0]), 32'd62);
      check("wrap_w1", 32'(cap[1]), 32'd63);
      check("wrap_w2", 32'(cap[2]), 32'd0);
      check("wrap_w3", 32'(cap[3]), 32'd1);
      check("wrap_done_at", 32'(done_at), 32'd3);

      // Burst 0, len 3 with two hold cycles; rd_en during the burst is dropped.
      do_cycle(burst(0, 3));
      do_cycle(nop());
      check("hold_w0", {31'd0, rd_valid}, 32'd1);
      check("hold_d0", 32'(rd_data), 32'd0);
      s = rd(nop(), 5); s.hold = 1;
      do_cycle(s);
      check("hold_gap1", 32'(rd_valid), 32'd0);
      do_cycle(s);
      check("hold_gap2", 32'(rd_valid), 32'd0);
      do_cycle(nop());
      check("hold_d1", 32'(rd_data), 32'd1);
      do_cycle(nop());
      check("hold_d2", 32'(rd_data), 32'd2);
      check("hold_done", 32'(burst_done), 32'd1);
      do_cycle(rd(nop(), 5));
      check("last_rd_dropped", 32'(rd_valid), 32'd0);
      do_cycle(rd(nop(), 5));
      check("idle_rd_5", 32'(rd_data), 32'd5);

      // Reset mid-burst, then confirm no late burst_done and memory retained.
      do_cycle(burst(10, 8));
      for (int c = 0; c < 3; c++) do_cycle(nop());
      s = nop(); s.rst = 1;
      do_cycle(s);
      check("mid_rst_busy", 32'(burst_busy), 32'd0);
      check("mid_rst_valid", 32'(rd_valid), 32'd0);
      check("mid_rst_data", 32'(rd_data), 32'd0);
      dones = 0;
      for (int c = 0; c < 10; c++) begin
         do_cycle(nop());
         if (burst_done) dones++;
      end
      check("mid_rst_no_done", 32'(dones), 32'd0);
      do_cycle(rd(nop(), 12));
      check("mem_kept", 32'(rd_data), 32'd12);
      do_cycle(burst(4, 0));
      check("len0_busy_a", 32'(burst_busy), 32'd0);
      do_cycle(nop());
      check("len0_busy_b", 32'(burst_busy), 32'd0);

      // Parity injection.
      s = wr(20, 8'h01); s.inj = 1;
      do_cycle(s);
      do_cycle(rd(nop(), 20));
`ifdef SAMPLE_MEM_PARITY_EN
      check("perr_inj", 32'(rd_perr), 32'd1);
`else
      check("perr_inj", 32'(rd_perr), 32'd0);
`endif
      do_cycle(wr(20, 8'h01));
      do_cycle(rd(nop(), 20));
      check("perr_clean", 32'(rd_perr), 32'd0);

      // Random traffic against the model.
      for (int c = 0; c < 500; c++) begin
         s = nop();
         s.wr_en   = 1'($urandom % 2);
         s.wr_addr = ADDR_W'($urandom);
         s.wr_data = DATA_W'($urandom);
         s.inj     = 1'($urandom % 8 == 0);
         s.rd_en   = 1'($urandom % 2);
         s.rd_addr = ADDR_W'($urandom);
         s.bs      = 1'($urandom % 6 == 0);
         s.bbase   = ADDR_W'($urandom);
         s.blen    = ($urandom % 10 == 0) ? (ADDR_W+1)'(DEPTH) : (ADDR_W+1)'($urandom_range(0, 9));
         s.hold    = 1'($urandom % 4 == 0);
         do_cycle(s);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
